// File: rtl/sa_host_seq.sv
// Host-side job sequencer for the systolic-array top: streams 64 weight and 64 data bytes into the
// array, strobes start, waits a fixed time, then sweeps 64 output words out as a valid/ready stream.
module sa_host_seq #(
    parameter int X_W       = 8,
    parameter int MAC_W     = 19,
    parameter int N_LOAD    = 64,
    parameter int N_OUT     = 64,
    parameter int DONE_WAIT = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             go_i,
    input  logic [X_W-1:0]   in_data_i,
    input  logic             in_v_i,
    output logic             in_ready_o,
    output logic [7:0]       addr_o,
    output logic [X_W-1:0]   data_o,
    output logic             wr_vo,
    input  logic [MAC_W-1:0] rdata_i,
    output logic [MAC_W-1:0] out_data_o,
    output logic             out_v_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = (DONE_WAIT > 1) ? $clog2(DONE_WAIT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_LOAD_D = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_READ   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [X_W-1:0]   data_q, data_d;
    logic             wr_q, wr_d;
    logic [MAC_W-1:0] odata_q, odata_d;
    logic             ov_q, ov_d;
    logic             rd_last_q, rd_last_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic beat_s;
    logic last_load_s;
    logic wait_end_s;
    logic cap_s;
    logic fin_s;

    // rdy_q tracks the LOAD states exactly, so it doubles as the beat qualifier
    assign beat_s      = in_v_i & rdy_q;
    assign last_load_s = (idx_q == 6'(N_LOAD - 1));
    assign wait_end_s  = (cnt_q == CNT_W'(DONE_WAIT - 1));
    assign cap_s       = (state_q == S_READ) & ~rd_last_q & (~ov_q | out_ready_i);
    assign fin_s       = (state_q == S_READ) & rd_last_q & ov_q & out_ready_i;

    // Next-state and next-output computation for the job sequence
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = 1'b0;
        odata_d   = odata_q;
        ov_d      = ov_q;
        rd_last_d = rd_last_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    state_d = S_LOAD_W;
                    idx_d   = 6'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_W: begin
                if (beat_s) begin
                    addr_d = {2'b00, idx_q};
                    data_d = in_data_i;
                    wr_d   = 1'b1;
                    if (last_load_s) begin
                        state_d = S_LOAD_D;
                        idx_d   = 6'd0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    wr_d = 1'b0;
                end
            end
            S_LOAD_D: begin
                if (beat_s) begin
                    addr_d = {2'b01, idx_q};
                    data_d = in_data_i;
                    wr_d   = 1'b1;
                    if (last_load_s) begin
                        state_d = S_START;
                        idx_d   = 6'd0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    wr_d = 1'b0;
                end
            end
            S_START: begin
                addr_d  = 8'hC0;
                data_d  = {X_W{1'b0}};
                wr_d    = 1'b1;
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wait_end_s) begin
                    addr_d    = 8'h80;
                    idx_d     = 6'd0;
                    rd_last_d = 1'b0;
                    state_d   = S_READ;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_READ: begin
                if (cap_s) begin
                    odata_d = rdata_i;
                    ov_d    = 1'b1;
                    // the final word parks the address instead of wrapping mid-phase
                    if (idx_q == 6'(N_OUT - 1)) begin
                        rd_last_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        addr_d = {2'b10, idx_q + 6'd1};
                    end
                end else if (fin_s) begin
                    ov_d      = 1'b0;
                    done_d    = 1'b1;
                    idx_d     = 6'd0;
                    rd_last_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 6'd0;
            end
        endcase
    end

    assign rdy_d  = (state_d == S_LOAD_W) | (state_d == S_LOAD_D);
    assign busy_d = (state_d != S_IDLE);

    // State and registered-output update with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            cnt_q     <= {CNT_W{1'b0}};
            addr_q    <= 8'd0;
            data_q    <= {X_W{1'b0}};
            wr_q      <= 1'b0;
            odata_q   <= {MAC_W{1'b0}};
            ov_q      <= 1'b0;
            rd_last_q <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            odata_q   <= odata_d;
            ov_q      <= ov_d;
            rd_last_q <= rd_last_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in_ready_o = rdy_q;
    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign wr_vo      = wr_q;
    assign out_data_o = odata_q;
    assign out_v_o    = ov_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_sa_host_seq.sv
// Bench for sa_host_seq: a job-level model (write list, strobe time, result order) checked every cycle,
// plus literal pins on timing spans and first/last result values.
module tb_sa_host_seq;

    localparam int MAC_W = 19;
    localparam int DW    = 32;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             go_i = 1'b0;
    logic [7:0]       in_data_i = 8'd0;
    logic             in_v_i = 1'b0;
    logic             out_ready_i = 1'b0;
    logic             in_ready_o, wr_vo, out_v_o, busy_o, done_o;
    logic [7:0]       addr_o, data_o;
    logic [MAC_W-1:0] rdata_i, out_data_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int rcyc = 0;
    int salt = 0;

    // model state
    bit        m_busy, m_pend_v, m_outv, m_done, cur_busy;
    int        m_acc, m_res, m_strobe;
    logic [7:0] m_pend_a, m_pend_d;

    // observations for the literal pins
    int obs_w_cnt, obs_wr_before, obs_first_wr_cyc, obs_first_addr, obs_strobe_cyc;
    int obs_first_out_cyc, obs_res_cnt, obs_done_cnt;
    logic [MAC_W-1:0] obs_first_res, obs_last_res;

    function automatic logic [MAC_W-1:0] arr_f(input logic [7:0] a);
        return (19'(a) * 19'd1031) ^ 19'h15A3C;
    endfunction

    assign rdata_i = arr_f(addr_o);

    sa_host_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .go_i(go_i),
        .in_data_i(in_data_i), .in_v_i(in_v_i), .in_ready_o(in_ready_o),
        .addr_o(addr_o), .data_o(data_o), .wr_vo(wr_vo), .rdata_i(rdata_i),
        .out_data_o(out_data_o), .out_v_o(out_v_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        #1;
        case (rdy_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = (rcyc % 3 == 0);
            default: out_ready_i = 1'($urandom_range(0, 1));
        endcase
        rcyc++;
    end

    // per-cycle compare against the job model, then advance it by this cycle's handshakes
    initial forever begin
        @(negedge clk_i);
        cyc++;
        if (!rst_ni) begin
            chk("reset_outputs", 64'({in_ready_o, addr_o, data_o, wr_vo, out_data_o, out_v_o, busy_o, done_o}), 64'd0);
            m_busy = 0; m_pend_v = 0; m_outv = 0; m_done = 0;
            m_acc = 0; m_res = 0; m_strobe = -1;
        end else begin
            chk("in_ready", 64'(in_ready_o), 64'(m_busy && m_acc < 128));
            chk("busy", 64'(busy_o), 64'(m_busy));
            chk("done", 64'(done_o), 64'(m_done));
            chk("wr_v", 64'(wr_vo), 64'(m_pend_v));
            if (m_pend_v) begin
                chk("wr_addr", 64'(addr_o), 64'(m_pend_a));
                chk("wr_data", 64'(data_o), 64'(m_pend_d));
            end
            chk("out_v", 64'(out_v_o), 64'(m_outv));
            if (m_outv) chk("out_data", 64'(out_data_o), 64'(arr_f(8'h80 + 8'(m_res))));
            if (m_strobe >= 0 && cyc == m_strobe + DW) chk("read_addr0", 64'(addr_o), 64'h80);

            if (wr_vo) begin
                if (addr_o == 8'hC0) begin
                    obs_strobe_cyc = cyc;
                    obs_wr_before  = obs_w_cnt;
                end else begin
                    if (obs_w_cnt == 0) begin
                        obs_first_wr_cyc = cyc;
                        obs_first_addr   = int'(addr_o);
                    end
                    obs_w_cnt++;
                end
            end
            if (out_v_o && obs_first_out_cyc < 0) obs_first_out_cyc = cyc;
            if (out_v_o && out_ready_i) begin
                if (obs_res_cnt == 0) obs_first_res = out_data_o;
                if (obs_res_cnt == 63) obs_last_res = out_data_o;
                obs_res_cnt++;
            end
            if (done_o) obs_done_cnt++;

            cur_busy = m_busy;
            m_done   = 0;
            if (cur_busy && m_acc < 128 && in_v_i) begin
                m_pend_v = 1; m_pend_a = 8'(m_acc); m_pend_d = in_data_i;
                m_acc++;
                if (m_acc == 128) m_strobe = cyc + 2;
            end else if (m_strobe >= 0 && cyc + 1 == m_strobe) begin
                m_pend_v = 1; m_pend_a = 8'hC0; m_pend_d = 8'h00;
            end else begin
                m_pend_v = 0;
            end
            if (m_outv && out_ready_i) begin
                m_res++;
                if (m_res == 64) begin
                    m_outv = 0; m_done = 1; m_busy = 0;
                end
            end else if (m_strobe >= 0 && cyc + 1 == m_strobe + DW + 1) begin
                m_outv = 1;
            end
            if (!cur_busy && go_i) begin
                m_busy = 1; m_acc = 0; m_res = 0; m_strobe = -1;
            end
        end
    end

    task automatic pulse_go();
        @(posedge clk_i);
        #1;
        go_i = 1'b1;
        obs_w_cnt = 0; obs_wr_before = -1; obs_first_wr_cyc = -1; obs_first_addr = -1;
        obs_strobe_cyc = -1; obs_first_out_cyc = -1; obs_res_cnt = 0; obs_done_cnt = 0;
        obs_first_res = '0; obs_last_res = '0;
    endtask

    task automatic stream(input int n, input bit gaps);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 3000) begin
            @(posedge clk_i);
            #1;
            go_i      = 1'b0;
            in_v_i    = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data_i = 8'(sent * 37 + 11 + salt);
            @(negedge clk_i);
            if (in_v_i && in_ready_o) sent++;
            guard++;
        end
        @(posedge clk_i);
        #1;
        in_v_i = 1'b0;
        go_i   = 1'b0;
        if (sent < n) chk("stream_timeout", 64'(sent), 64'(n));
    endtask

    task automatic wait_done(input int lim);
        int g = 0;
        while (!done_o && g < lim) begin
            @(negedge clk_i);
            g++;
        end
        chk("done_seen", 64'(done_o), 64'd1);
        #1;
    endtask

    task automatic job_checks(input bit full);
        chk("wr_count", 64'(obs_wr_before), 64'd128);
        chk("first_wr_addr", 64'(obs_first_addr), 64'd0);
        if (full) chk("load_span", 64'(obs_strobe_cyc - obs_first_wr_cyc), 64'd128);
        chk("wait_span", 64'(obs_first_out_cyc - obs_strobe_cyc), 64'd33);
        chk("first_result", 64'(obs_first_res), 64'h359BC);
        chk("last_result", 64'(obs_last_res), 64'h25B05);
        chk("result_count", 64'(obs_res_cnt), 64'd64);
        chk("done_count", 64'(obs_done_cnt), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;

        // stream offered while idle, no go
        @(posedge clk_i);
        #1;
        obs_w_cnt = 0;
        in_v_i = 1'b1;
        in_data_i = 8'hA5;
        repeat (8) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        in_v_i = 1'b0;
        chk("idle_no_write", 64'(obs_w_cnt), 64'd0);

        // full job, continuous stream, always ready
        rdy_mode = 0; salt = 0;
        pulse_go(); stream(128, 1'b0); wait_done(1000); job_checks(1'b1);

        // back-to-back job with input gaps and 1-in-3 output ready
        rdy_mode = 1; salt = 5;
        pulse_go(); stream(128, 1'b1); wait_done(1000); job_checks(1'b0);

        // go pulsed during WAIT is ignored; random output ready
        rdy_mode = 2; salt = 9;
        pulse_go(); stream(128, 1'b0);
        repeat (10) @(posedge clk_i);
        #1; go_i = 1'b1;
        @(posedge clk_i);
        #1; go_i = 1'b0;
        wait_done(1000); job_checks(1'b1);

        // reset in LOAD_D at idx 20
        rdy_mode = 0; salt = 3;
        pulse_go(); stream(84, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_reset", 64'({in_ready_o, addr_o, data_o, wr_vo, out_data_o, out_v_o, busy_o, done_o}), 64'd0);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        chk("post_reset_ready", 64'(in_ready_o), 64'd0);
        chk("post_reset_busy", 64'(busy_o), 64'd0);

        // recovery job after reset
        salt = 7;
        pulse_go(); stream(128, 1'b1); wait_done(1000); job_checks(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
